// File: rtl/bcd_seg_pkg.sv
// -----------------------------------------------------------------------------
// bcd_seg_pkg
// Shared definitions for the two-digit multiplexed seven-segment driver:
//   - state_e    : refresh FSM states, visited in declaration order
//   - SEG_BLANK  : all segments off (active-low)
//   - SEG_DASH   : segment g only, shown for hold values 10..15
//   - SEG_TABLE  : active-low segment patterns for digits 0..9, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    SHOW_LSB = 2'd0,
    GAP_A    = 2'd1,
    SHOW_MSB = 2'd2,
    GAP_B    = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 is the rightmost element of the concatenation.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage : bcd_seg_pkg

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   digit : 4-bit BCD digit; values 10..15 are shown as a dash
//   seg   : active-low segments, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg
  import bcd_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    seg = SEG_DASH;
    if (digit <= MAX_DIGIT) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule : bcd_to_seg

// File: rtl/bcd_seg_mux.sv
// -----------------------------------------------------------------------------
// bcd_seg_mux
// Two-digit multiplexed seven-segment driver with dead-time between digits,
// leading-zero blanking of the tens digit and a sticky invalid-digit flag.
// Parameters:
//   REFRESH_DIV : cycles each digit is lit (>= 1)
//   DEAD_CYCLES : cycles with all anodes off between digits (>= 1)
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous active-high reset, takes priority over load
//   bcd_lsb  : units digit from the upstream BCD counter
//   bcd_msb  : tens digit from the upstream BCD counter
//   load     : capture strobe for both digits
//   blank_lz : enables leading-zero blanking of the tens digit
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   an       : active-low anodes, an[0] = units, an[1] = tens
//   err      : sticky flag, set by any capture of a digit above 9
// -----------------------------------------------------------------------------
module bcd_seg_mux
  import bcd_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd_lsb,
  input  logic [3:0] bcd_msb,
  input  logic       load,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] SHOW_RELOAD = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(DEAD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hold_lsb_q, hold_lsb_d;
  logic [3:0]       hold_msb_q, hold_msb_d;
  logic             err_q, err_d;
  logic             blank_q;

  logic [3:0]       digit_sel;
  logic [6:0]       digit_seg;

  // ---------------------------------------------------------------------------
  // Refresh FSM: one down-counter, reloaded on every state change, times both
  // the lit windows and the dead gaps.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    if (cnt_q == '0) begin
      unique case (state_q)
        SHOW_LSB: begin state_d = GAP_A;    cnt_d = GAP_RELOAD;  end
        GAP_A:    begin state_d = SHOW_MSB; cnt_d = SHOW_RELOAD; end
        SHOW_MSB: begin state_d = GAP_B;    cnt_d = GAP_RELOAD;  end
        GAP_B:    begin state_d = SHOW_LSB; cnt_d = SHOW_RELOAD; end
        default:  begin state_d = SHOW_LSB; cnt_d = SHOW_RELOAD; end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture: both digits load together so a displayed pair is never torn.
  // err is sticky; only reset clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_lsb_d = hold_lsb_q;
    hold_msb_d = hold_msb_q;
    err_d      = err_q;
    if (load) begin
      hold_lsb_d = bcd_lsb;
      hold_msb_d = bcd_msb;
      if ((bcd_lsb > MAX_DIGIT) || (bcd_msb > MAX_DIGIT)) begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SHOW_LSB;
      cnt_q      <= SHOW_RELOAD;
      hold_lsb_q <= '0;
      hold_msb_q <= '0;
      err_q      <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_lsb_q <= hold_lsb_d;
      hold_msb_q <= hold_msb_d;
      err_q      <= err_d;
      // blank_lz is sampled every cycle; registering it keeps the outputs
      // purely Moore with no input-to-output combinational path.
      blank_q    <= blank_lz;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: a single decoder shared by both digits through a mux.
  // ---------------------------------------------------------------------------
  assign digit_sel = (state_q == SHOW_MSB) ? hold_msb_q : hold_lsb_q;

  bcd_to_seg u_bcd_to_seg (
    .digit (digit_sel),
    .seg   (digit_seg)
  );

  always_comb begin
    seg = SEG_BLANK;
    an  = 2'b11;
    unique case (state_q)
      SHOW_LSB: begin
        an  = 2'b10;
        seg = digit_seg;
      end
      SHOW_MSB: begin
        // A blanked leading zero keeps the window timing but lights nothing.
        if (!(blank_q && (hold_msb_q == 4'd0))) begin
          an  = 2'b01;
          seg = digit_seg;
        end
      end
      default: begin
        an  = 2'b11;
        seg = SEG_BLANK;
      end
    endcase
  end

  assign err = err_q;

endmodule : bcd_seg_mux

// File: tb/tb_bcd_seg_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_mux
// Self-checking bench for bcd_seg_mux with REFRESH_DIV=4, DEAD_CYCLES=2.
// A period-position model predicts seg/an/err every cycle; directed vectors
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_seg_mux;

  localparam int RD     = 4;
  localparam int DC     = 2;
  localparam int PERIOD = 2 * (RD + DC);

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bcd_lsb;
  logic [3:0] bcd_msb;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int checks   = 0;
  int failures = 0;

  bcd_seg_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_lsb  (bcd_lsb),
    .bcd_msb  (bcd_msb),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position within the 12-cycle period plus the held pair.
  // ---------------------------------------------------------------------------
  logic [6:0] dec_ref [16];
  initial begin
    dec_ref[0] = 7'h40; dec_ref[1] = 7'h79; dec_ref[2] = 7'h24; dec_ref[3] = 7'h30;
    dec_ref[4] = 7'h19; dec_ref[5] = 7'h12; dec_ref[6] = 7'h02; dec_ref[7] = 7'h78;
    dec_ref[8] = 7'h00; dec_ref[9] = 7'h10;
    for (int i = 10; i < 16; i++) dec_ref[i] = 7'h3F;
  end

  int         m_pos   = 0;
  logic [3:0] m_lsb   = 4'd0;
  logic [3:0] m_msb   = 4'd0;
  logic       m_err   = 1'b0;
  logic       m_blank = 1'b0;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos   <= 0;
      m_lsb   <= 4'd0;
      m_msb   <= 4'd0;
      m_err   <= 1'b0;
      m_blank <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_pos   <= (m_pos + 1) % PERIOD;
      m_blank <= blank_lz;
      if (load) begin
        m_lsb <= bcd_lsb;
        m_msb <= bcd_msb;
        if (bcd_lsb > 4'd9 || bcd_msb > 4'd9) m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_an;
    logic [6:0] e_seg;
    if (m_valid) begin
      e_an  = 2'b11;
      e_seg = 7'h7F;
      if (m_pos < RD) begin
        e_an  = 2'b10;
        e_seg = dec_ref[m_lsb];
      end else if (m_pos >= RD + DC && m_pos < 2 * RD + DC) begin
        if (!(m_blank && m_msb == 4'd0)) begin
          e_an  = 2'b01;
          e_seg = dec_ref[m_msb];
        end
      end
      check("model_an", 32'(an), 32'(e_an));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_err", 32'(err), 32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input logic [1:0] target, input string name);
    int n = 0;
    while (an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(an), 32'(target));
  endtask

  task automatic count_lsb_window(input string name);
    int n = 0;
    while (an === 2'b10 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(RD));
  endtask

  task automatic do_load(input logic [3:0] lsb, input logic [3:0] msb);
    bcd_lsb = lsb;
    bcd_msb = msb;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  logic [1:0] exp_seq [PERIOD];

  initial begin
    int n;
    reset    = 1'b1;
    load     = 1'b0;
    bcd_lsb  = 4'd0;
    bcd_msb  = 4'd0;
    blank_lz = 1'b0;
    step(2);

    // Reset state.
    check("rst_an", 32'(an), 32'h2);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_err", 32'(err), 32'h0);

    // Release: lit exactly RD cycles, then one full period of anodes.
    reset = 1'b0;
    count_lsb_window("first_lsb_window");
    for (int i = 0; i < PERIOD; i++) begin
      exp_seq[i] = (i < 2) ? 2'b11 : (i < 6) ? 2'b01 : (i < 8) ? 2'b11 : 2'b10;
    end
    for (int i = 0; i < PERIOD; i++) begin
      check("an_sequence", 32'(an), 32'(exp_seq[i]));
      if (an !== 2'b11) check("show_seg_zero", 32'(seg), 32'h40);
      step();
    end

    // 73 loaded: units 7, tens 3.
    do_load(4'd7, 4'd3);
    wait_an(2'b10, "wait_lsb_73");
    check("seg_7", 32'(seg), 32'h78);
    wait_an(2'b01, "wait_msb_73");
    check("seg_3", 32'(seg), 32'h30);
    check("err_after_73", 32'(err), 32'h0);

    // 05 with leading-zero blanking: tens window dark for its whole length.
    blank_lz = 1'b1;
    do_load(4'd5, 4'd0);
    wait_an(2'b10, "wait_lsb_05");
    check("seg_5", 32'(seg), 32'h12);
    n = 0;
    while (an === 2'b10 && n < 20) begin n++; step(); end
    n = 0;
    while (an === 2'b11 && n < 20) begin n++; step(); end
    check("blank_dark_cycles", 32'(n), 32'(2 * DC + RD));
    blank_lz = 1'b0;
    wait_an(2'b01, "wait_msb_noblank");
    check("seg_0_unblanked", 32'(seg), 32'h40);

    // Invalid units digit: dash and sticky err.
    do_load(4'hC, 4'd1);
    check("err_set", 32'(err), 32'h1);
    wait_an(2'b10, "wait_lsb_dash");
    check("seg_dash", 32'(seg), 32'h3F);
    do_load(4'd2, 4'd2);
    check("err_sticky", 32'(err), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", 32'(err), 32'h0);

    // Reset pulse in the second cycle of the tens window.
    do_load(4'd8, 4'd6);
    wait_an(2'b01, "wait_msb_86");
    step();
    reset = 1'b1;
    step();
    check("midrst_an", 32'(an), 32'h2);
    check("midrst_seg", 32'(seg), 32'h40);
    reset = 1'b0;
    count_lsb_window("midrst_lsb_window");

    // load together with reset: reset wins.
    bcd_lsb = 4'd9;
    bcd_msb = 4'd8;
    load    = 1'b1;
    reset   = 1'b1;
    step();
    load    = 1'b0;
    reset   = 1'b0;
    check("rst_load_lsb", 32'(seg), 32'h40);
    wait_an(2'b01, "wait_msb_rstload");
    check("rst_load_msb", 32'(seg), 32'h40);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_bcd_seg_mux

// File: doc/bcd_seg_mux.md
BCD_SEG_MUX -- requirements
Module: bcd_seg_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles each digit is lit; legal values are 1 and above.
REQ-003 Parameter DEAD_CYCLES, default 4, SHALL set the clock cycles with all anodes off between digits (anti-ghosting); legal values are 1 and above.
REQ-004 Port clk, input, 1 bit, SHALL be the system clock.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port bcd_lsb, input, 4 bits, SHALL carry the units digit from the upstream BCD counter.
REQ-007 Port bcd_msb, input, 4 bits, SHALL carry the tens digit from the upstream BCD counter.
REQ-008 Port load, input, 1 bit, SHALL be the capture strobe for both digits.
REQ-009 Port blank_lz, input, 1 bit, SHALL enable leading-zero blanking of the tens digit.
REQ-010 Port seg, output, 7 bits, SHALL carry the active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 Port an, output, 2 bits, SHALL carry the active-low anodes: an[0] drives the units digit and an[1] drives the tens digit.
REQ-012 Port err, output, 1 bit, SHALL be the sticky invalid-digit flag.

Function
REQ-013 On a clock edge with load=1 and reset=0, hold_lsb and hold_msb SHALL capture bcd_lsb and bcd_msb together, so a displayed pair is never torn.
REQ-014 A captured value SHALL become visible on seg in the cycle after the capture edge, if the matching digit is being shown.
REQ-015 With load=0 the hold registers SHALL keep their values; capture SHALL be legal in any state.
REQ-016 The FSM SHALL have four states, SHOW_LSB, GAP_A, SHOW_MSB and GAP_B, visited cyclically in that order.
REQ-017 Each SHOW state SHALL last REFRESH_DIV cycles and each GAP state SHALL last DEAD_CYCLES cycles, timed by one down-counter reloaded on every state change.
REQ-018 The full refresh period SHALL be 2*(REFRESH_DIV+DEAD_CYCLES) cycles.
REQ-019 Outputs SHALL be Moore, decoded from the state and hold registers only, with no input-to-output combinational path.
REQ-020 In SHOW_LSB: an=2'b10 and seg=decode(hold_lsb).
REQ-021 In SHOW_MSB: an=2'b01 and seg=decode(hold_msb).
REQ-022 In GAP_A and GAP_B: an=2'b11 and seg=7'h7F.
REQ-023 Decode for digits 0-9 SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (all hex).
REQ-024 A hold value of 10-15 SHALL display a dash, seg=7'h3F (segment g only).
REQ-025 Leading-zero blanking: in SHOW_MSB with blank_lz=1 and hold_msb=0, the block SHALL force an=2'b11 and seg=7'h7F; state timing SHALL be unchanged.
REQ-026 blank_lz SHALL be sampled live each cycle.
REQ-027 err SHALL assert on the cycle after any load edge that captures a digit above 9, and SHALL then stay high until reset.
REQ-028 A later valid load SHALL NOT clear err.
REQ-029 The units digit SHALL never be blanked.

Reset
REQ-030 While reset=1: state=SHOW_LSB, counter=REFRESH_DIV-1, hold_lsb=0, hold_msb=0, err=0; therefore an=2'b10, seg=7'h40, err=0.
REQ-031 reset SHALL take priority over load.
REQ-032 Reset asserted mid-period SHALL return the block to the REQ-030 state on the next edge.
REQ-033 After reset deasserts, an=2'b10 SHALL hold for exactly REFRESH_DIV cycles, counting the first cycle with reset low.

Structure
REQ-034 Package bcd_seg_pkg SHALL hold the state enumeration, SEG_BLANK=7'h7F, SEG_DASH=7'h3F and the digit-to-segment table.
REQ-035 A single combinational sub-module, bcd_to_seg (4-bit digit in, 7-bit active-low segments out), SHALL implement REQ-023 and REQ-024 and SHALL be instantiated once, fed by a digit mux.

Verification (REFRESH_DIV=4, DEAD_CYCLES=2, period 12)
REQ-036 Reset release -> an sequence SHALL be 10 x4, 11 x2, 01 x4, 11 x2, repeating; seg=7'h40 in both SHOW states.
REQ-037 load with lsb=7, msb=3 -> next cycles in SHOW_LSB give seg=7'h78; in SHOW_MSB give seg=7'h30; err stays 0.
REQ-038 load with msb=0, lsb=5, blank_lz=1 -> an=11 throughout the SHOW_MSB window; with blank_lz=0 -> an=01 and seg=7'h40.
REQ-039 load with lsb=4'hC -> dash 7'h3F in SHOW_LSB and err=1 from the next cycle; a following valid load keeps err=1; reset clears err.
REQ-040 Reset pulse during SHOW_MSB cycle 2 -> an=10 and seg=7'h40 the next cycle, then a full 4-cycle SHOW_LSB window.
REQ-041 load and reset asserted in the same cycle -> hold registers read 0.
